// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped, write-through, no-write-allocate data cache controller
// Ports:
//   clk, CpuRst_n               clock, synchronous active-low reset
//   A, WD, WE, RE               MEM-stage request (byte address, store data, byte enables, load)
//   RD, DCacheMiss              load data, pipeline stall request
//   MemReq, MemWe, MemAddr,
//   MemWData, MemWStrb          memory beat request (one word per beat)
//   MemAck, MemRData            memory beat completion and read data
module dcache_ctrl (
  input  logic        clk,
  input  logic        CpuRst_n,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [3:0]  WE,
  input  logic        RE,
  output logic [31:0] RD,
  output logic        DCacheMiss,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemWStrb,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] WDONE  = 2'd3;

  logic [1:0]  state;
  logic [7:0]  valid;
  logic [24:0] tags  [0:7];
  logic [31:0] words [0:31];   // {index, word offset}

  // Latched request: word address, store data/strobes, and hit at issue time
  logic [31:2] a_q;
  logic [31:0] wd_q;
  logic [3:0]  we_q;
  logic        hit_q;
  logic [1:0]  cnt;

  logic        hit;
  logic [31:0] merged;
  logic        unused_low;

  assign unused_low = ^A[1:0];
  assign hit = valid[A[6:4]] && (tags[A[6:4]] == A[31:7]);

  // Byte-lane merge of the latched store into the currently cached word
  always_comb begin
    merged = words[a_q[6:2]];
    for (int b = 0; b < 4; b++) begin
      if (we_q[b]) merged[8*b +: 8] = wd_q[8*b +: 8];
    end
  end

  always_comb begin
    RD         = '0;
    DCacheMiss = 1'b0;
    MemReq     = 1'b0;
    MemWe      = 1'b0;
    MemAddr    = '0;
    MemWData   = '0;
    MemWStrb   = '0;
    if (CpuRst_n) begin
      case (state)
        IDLE: begin
          if (WE != 4'd0) begin
            DCacheMiss = 1'b1;
          end else if (RE) begin
            if (hit) RD = words[A[6:2]];
            else     DCacheMiss = 1'b1;
          end
        end
        REFILL: begin
          DCacheMiss = 1'b1;
          MemReq     = 1'b1;
          MemAddr    = {a_q[31:4], cnt, 2'b00};
        end
        WRITE: begin
          DCacheMiss = 1'b1;
          MemReq     = 1'b1;
          MemWe      = 1'b1;
          MemAddr    = {a_q, 2'b00};
          MemWData   = wd_q;
          MemWStrb   = we_q;
        end
        default: ;  // WDONE: one quiet cycle lets the pipeline retire the store
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!CpuRst_n) begin
      state <= IDLE;
      valid <= '0;
      cnt   <= '0;
      a_q   <= '0;
      wd_q  <= '0;
      we_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (WE != 4'd0) begin
            a_q   <= A[31:2];
            wd_q  <= WD;
            we_q  <= WE;
            hit_q <= hit;
            state <= WRITE;
          end else if (RE && !hit) begin
            a_q   <= A[31:2];
            cnt   <= 2'd0;
            state <= REFILL;
          end
        end
        REFILL: begin
          if (MemAck) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              valid[a_q[6:4]] <= 1'b1;
              state           <= IDLE;
            end
          end
        end
        WRITE: begin
          if (MemAck) state <= WDONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; a line is only trusted once valid is set
  always_ff @(posedge clk) begin
    if (CpuRst_n) begin
      if (state == REFILL && MemAck) begin
        words[{a_q[6:4], cnt}] <= MemRData;
        if (cnt == 2'd3) tags[a_q[6:4]] <= a_q[31:7];
      end
      if (state == WRITE && MemAck && hit_q) words[a_q[6:2]] <= merged;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        CpuRst_n;
  logic [31:0] A, WD;
  logic [3:0]  WE;
  logic        RE;
  logic [31:0] RD;
  logic        DCacheMiss, MemReq, MemWe;
  logic [31:0] MemAddr, MemWData;
  logic [3:0]  MemWStrb;
  logic        MemAck = 1'b0;
  logic [31:0] MemRData = 32'h0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .CpuRst_n(CpuRst_n), .A(A), .WD(WD), .WE(WE), .RE(RE), .RD(RD),
    .DCacheMiss(DCacheMiss), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWStrb(MemWStrb), .MemAck(MemAck), .MemRData(MemRData)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;
  beat_t beats[$];

  logic [31:0] mem     [int unsigned];
  logic [31:0] exp_mem [int unsigned];
  int          res_tag [8];
  bit          ack_always = 1'b1;
  bit          ack_noise  = 1'b0;

  bit          prev_req = 1'b0;
  bit          prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [31:0] prev_wdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Memory: acks requested beats (always or with random latency), optionally
  // toggles MemAck while nothing is requested, and logs every completed beat.
  always @(negedge clk) begin
    MemAck   = 1'b0;
    MemRData = $urandom;
    if (MemReq === 1'b1) begin
      if (prev_req && !prev_ack) begin
        chk("mem_addr_hold", MemAddr, prev_addr);
        if (MemWe === 1'b1) chk("mem_wdata_hold", MemWData, prev_wdata);
      end
      if (ack_always || $urandom_range(0, 2) == 0) begin
        MemAck = 1'b1;
        beats.push_back('{MemWe, MemAddr, (MemWe ? MemWData : mem_rd(MemAddr)), MemWStrb});
        if (MemWe === 1'b1) mem[MemAddr] = merge(mem_rd(MemAddr), MemWData, MemWStrb);
        else                MemRData = mem_rd(MemAddr);
      end
    end else if (ack_noise) begin
      MemAck = ($urandom_range(0, 1) == 1);
    end
    prev_req   = (MemReq === 1'b1);
    prev_ack   = MemAck;
    prev_addr  = MemAddr;
    prev_wdata = MemWData;
  end

  task automatic clear_model();
    for (int i = 0; i < 8; i++) res_tag[i] = -1;
  endtask

  task automatic do_reset(input int cycles);
    CpuRst_n = 1'b0;
    A = 32'h100; RE = 1'b1; WE = 4'd0; WD = 32'h0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_miss", DCacheMiss, 0);
      chk("rst_memreq", MemReq, 0);
      chk("rst_rd", RD, 0);
      @(posedge clk); #1;
    end
    CpuRst_n = 1'b1;
    RE = 1'b0;
    clear_model();
  endtask

  // Load: checks stall, beats and data against the line-residency model and exp_mem
  task automatic do_load(input logic [31:0] a, output logic [31:0] rd, output bit miss0, output int n);
    bit          exp_miss;
    int          idx, tg;
    logic [31:0] base;
    idx  = int'(a[6:4]);
    tg   = int'(a[31:7]);
    base = {a[31:4], 4'h0};
    exp_miss = (res_tag[idx] != tg);
    beats.delete();
    A = a; RE = 1'b1; WE = 4'd0; WD = $urandom;
    @(negedge clk);
    miss0 = DCacheMiss;
    n = 0;
    while (DCacheMiss === 1'b1 && n < 200) begin
      @(posedge clk); #1; @(negedge clk);
      n++;
    end
    if (n >= 200) chk("ld_timeout", 1, 0);
    rd = RD;
    chk("ld_req_at_hit", MemReq, 0);
    @(posedge clk); #1;
    RE = 1'b0;
    chk("ld_miss", miss0, exp_miss);
    chk("ld_rd", rd, exp_rd({a[31:2], 2'b00}));
    chk("ld_nbeats", beats.size(), exp_miss ? 4 : 0);
    for (int i = 0; i < beats.size() && i < 4; i++) begin
      chk("ld_beat_we", beats[i].we, 0);
      chk("ld_beat_addr", beats[i].addr, base + 32'(4 * i));
    end
    res_tag[idx] = tg;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit re, output int n);
    bit m0;
    beats.delete();
    A = a; WD = d; WE = s; RE = re;
    @(negedge clk);
    m0 = DCacheMiss;
    n = 0;
    while (DCacheMiss === 1'b1 && n < 200) begin
      @(posedge clk); #1; @(negedge clk);
      n++;
    end
    if (n >= 200) chk("st_timeout", 1, 0);
    chk("st_wdone_req", MemReq, 0);
    chk("st_wdone_rd", RD, 0);
    @(posedge clk); #1;
    WE = 4'd0; RE = 1'b0; A = $urandom;
    @(negedge clk);
    chk("st_after_miss", DCacheMiss, 0);
    chk("st_after_req", MemReq, 0);
    @(posedge clk); #1;
    chk("st_miss0", m0, 1);
    exp_mem[{a[31:2], 2'b00}] = merge(exp_rd({a[31:2], 2'b00}), d, s);
    chk("st_nbeats", beats.size(), 1);
    if (beats.size() >= 1) begin
      chk("st_beat_we", beats[0].we, 1);
      chk("st_beat_addr", beats[0].addr, {a[31:2], 2'b00});
      chk("st_beat_data", beats[0].data, d);
      chk("st_beat_strb", beats[0].strb, s);
    end
  endtask

  typedef struct {
    bit          st;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  we;
    bit          re;
    logic [31:0] rd;
    bit          miss;
  } vec_t;

  initial begin
    vec_t        tbl[10];
    logic [31:0] rd, a;
    bit          m0;
    int          n;

    CpuRst_n = 1'b0; A = 0; WD = 0; WE = 0; RE = 0;
    clear_model();

    tbl[0] = '{1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 32'h11,       1'b1};
    tbl[1] = '{1'b0, 32'h108, 32'h0,        4'h0, 1'b1, 32'h33,       1'b0};
    tbl[2] = '{1'b1, 32'h104, 32'hAABBCCDD, 4'h3, 1'b0, 32'h0,        1'b1};
    tbl[3] = '{1'b0, 32'h104, 32'h0,        4'h0, 1'b1, 32'h0000CCDD, 1'b0};
    tbl[4] = '{1'b1, 32'h200, 32'h12345678, 4'hF, 1'b1, 32'h0,        1'b1};
    tbl[5] = '{1'b0, 32'h200, 32'h0,        4'h0, 1'b1, 32'h12345678, 1'b1};
    tbl[6] = '{1'b0, 32'h180, 32'h0,        4'h0, 1'b1, 32'h55,       1'b1};
    tbl[7] = '{1'b0, 32'h100, 32'h0,        4'h0, 1'b1, 32'h11,       1'b1};
    tbl[8] = '{1'b0, 32'h10F, 32'h0,        4'h0, 1'b1, 32'h44,       1'b0};
    tbl[9] = '{1'b0, 32'h182, 32'h0,        4'h0, 1'b1, 32'h55,       1'b1};

    foreach (tbl[i]) begin
      if (tbl[i].rd != 0 && !tbl[i].st && tbl[i].a[31:2] != 30'h41) begin
        mem[{tbl[i].a[31:2], 2'b00}]     = tbl[i].rd;
        exp_mem[{tbl[i].a[31:2], 2'b00}] = tbl[i].rd;
      end
    end
    mem[32'h104] = 32'h22; exp_mem[32'h104] = 32'h22;
    mem.delete(32'h200); exp_mem.delete(32'h200);

    do_reset(2);

    @(negedge clk);
    chk("idle_miss", DCacheMiss, 0);
    chk("idle_req", MemReq, 0);
    chk("idle_rd", RD, 0);
    @(posedge clk); #1;

    ack_always = 1'b1;
    ack_noise  = 1'b1;
    foreach (tbl[i]) begin
      if (tbl[i].st) begin
        do_store(tbl[i].a, tbl[i].wd, tbl[i].we, tbl[i].re, n);
        chk("tbl_st_cycles", n, 2);
      end else begin
        do_load(tbl[i].a, rd, m0, n);
        chk("tbl_ld_rd", rd, tbl[i].rd);
        chk("tbl_ld_miss", m0, tbl[i].miss);
        chk("tbl_ld_cycles", n, tbl[i].miss ? 5 : 0);
      end
    end

    do_reset(1);
    A = 32'h100; RE = 1'b1; WE = 4'd0;
    beats.delete();
    @(negedge clk); chk("ab_miss0", DCacheMiss, 1);
    @(posedge clk); #1; @(negedge clk); chk("ab_req1", MemReq, 1);
    @(posedge clk); #1; @(negedge clk); chk("ab_req2", MemReq, 1);
    @(posedge clk); #1;
    CpuRst_n = 1'b0;
    @(negedge clk); chk("ab_req_rst", MemReq, 0);
    @(posedge clk); #1; @(negedge clk); chk("ab_req_rst2", MemReq, 0);
    @(posedge clk); #1;
    CpuRst_n = 1'b1; RE = 1'b0;
    @(negedge clk);
    chk("ab_idle_req", MemReq, 0);
    chk("ab_idle_miss", DCacheMiss, 0);
    chk("ab_nbeats", beats.size(), 2);
    @(posedge clk); #1;
    clear_model();
    do_load(32'h100, rd, m0, n);
    chk("ab_reload_miss", m0, 1);
    chk("ab_reload_rd", rd, 32'h11);

    do_reset(1);
    ack_always = 1'b0;
    for (int k = 0; k < 300; k++) begin
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) begin
        do_load(a, rd, m0, n);
      end else begin
        do_store(a, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), n);
      end
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        chk("rnd_idle_req", MemReq, 0);
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 CpuRst_n  in  1  reset, synchronous and active-low.
REQ-003 A  in  32  byte address from MEM stage; [31:7] tag, [6:4] index, [3:2] word offset, [1:0] ignored.
REQ-004 WD  in  32  store data, byte-lane aligned.
REQ-005 WE  in  4  byte write enables; nonzero means store.
REQ-006 RE  in  1  load request (MemToRegM).
REQ-007 RD  out  32  load data.
REQ-008 DCacheMiss  out  1  stall request to the hazard unit; 1 means freeze F/D/E/M.
REQ-009 MemReq  out  1  memory request valid.
REQ-010 MemWe  out  1  1 means write beat, 0 means read beat.
REQ-011 MemAddr  out  32  word-aligned memory address.
REQ-012 MemWData  out  32  write data.
REQ-013 MemWStrb  out  4  write byte strobes.
REQ-014 MemAck  in  1  beat complete; read data valid on MemRData in the same cycle.
REQ-015 MemRData  in  32  memory read data.

Function
REQ-016 Organisation SHALL be direct-mapped, 8 lines x 4 words, write-through, no-write-allocate; each line has a valid bit and a 25-bit tag.
REQ-017 FSM states SHALL be IDLE, REFILL, WRITE, WDONE.
REQ-018 Hit SHALL be defined as valid[index] && tag[index]==A[31:7], evaluated combinationally in IDLE.
REQ-019 IDLE with WE!=0 SHALL set DCacheMiss=1 in the same cycle, latch A/WD/WE and hit, and go to WRITE; store has priority when RE and WE are both active.
REQ-020 IDLE with RE=1, WE=0 and hit SHALL give DCacheMiss=0 and RD=word[index][offset] in the same cycle (zero-latency hit).
REQ-021 IDLE with RE=1, WE=0 and miss SHALL set DCacheMiss=1 in the same cycle, latch A, clear beat counter, and go to REFILL.
REQ-022 RD SHALL be 0 whenever there is no read hit in IDLE.
REQ-023 In REFILL: MemReq=1, MemWe=0, MemAddr={tag,index,cnt,2'b00}; each MemAck SHALL write MemRData into word cnt and increment cnt (2-bit).
REQ-024 On MemAck with cnt==3, REFILL SHALL set valid and tag for the line and go to IDLE; the replayed load then hits, giving DCacheMiss=0 one cycle after the last ack.
REQ-025 In WRITE: MemReq=1, MemWe=1, with latched address, data and strobes held stable until MemAck.
REQ-026 On MemAck in WRITE, if the latched hit=1, the cached word SHALL be updated byte-wise per WE, and the FSM SHALL go to WDONE.
REQ-027 WDONE SHALL hold DCacheMiss=0 and MemReq=0 for exactly one cycle, regardless of RE/WE, then go to IDLE, so the pipeline advances past the store without reissuing it.
REQ-028 DCacheMiss SHALL be 1 in REFILL and WRITE in every cycle, including the cycle of the final MemAck.
REQ-029 MemAck SHALL be ignored when MemReq=0; MemReq SHALL be 0 in IDLE and WDONE.
REQ-030 MemReq MAY remain high between refill beats; MemAddr SHALL advance only after an ack.
REQ-031 RE=0 and WE=0 in IDLE SHALL cause no memory traffic and DCacheMiss=0.

Reset
REQ-032 When CpuRst_n=0 at a clock edge: all valid bits, cnt and latched request SHALL be cleared and state SHALL be IDLE; data and tag arrays need no reset.
REQ-033 While CpuRst_n=0: DCacheMiss=0, MemReq=0, RD=0.
REQ-034 Reset during REFILL or WRITE SHALL abort the transfer: MemReq=0 from the next cycle, the partially filled line stays invalid, and a late MemAck is ignored.

Verification
REQ-035 After reset, a load at A=0x100 SHALL give DCacheMiss=1 immediately and issue reads to 0x100, 0x104, 0x108, 0x10C; with MemRData=0x11,0x22,0x33,0x44, the next cycle SHALL give DCacheMiss=0 and RD=0x11.
REQ-036 Following REQ-035, a load at 0x108 SHALL hit with DCacheMiss=0 and RD=0x33 in the same cycle, with no MemReq.
REQ-037 A store at A=0x104, WD=0xAABBCCDD, WE=4'b0011 SHALL issue one write with MemWStrb=0011, keep DCacheMiss=1 until the ack, then give one WDONE cycle with DCacheMiss=0; a load at 0x104 SHALL then return 0x0000CCDD (given 0x22 previously).
REQ-038 A store miss at 0x200 SHALL issue one memory write, and a following load at 0x200 SHALL miss and refill.
REQ-039 A conflict at 0x180 (same index as 0x100, different tag) SHALL refill, after which a load at 0x100 SHALL miss again.
REQ-040 Asserting CpuRst_n=0 after the 2nd refill beat SHALL drop MemReq the next cycle, and a load at 0x100 after release SHALL miss.
